// File: rtl/axi_sram_slave_burst.sv
// axi_sram_slave_burst: AXI4 memory slave wrapping a behavioural word-addressed SRAM.
// One outstanding transaction at a time. Supports INCR and FIXED bursts (WRAP behaves as INCR),
// byte strobes, WLAST checking and fair AW/AR arbitration through a flip-on-grant priority pointer.
// Optional feature macro: AXI_SLV_DECERR_EN -- a start word index beyond the SRAM returns DECERR,
// drops write beats and reads zero; without it addresses alias modulo MEM_WORDS.
// Ports:
//   ck, rst             clock (rising edge), synchronous active-high reset
//   cs                  chip select, gates new address handshakes only
//   aw*/w*/b*           AXI4 write address, write data and write response channels
//   ar*/r*              AXI4 read address and read data channels
module axi_sram_slave_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int MEM_WORDS  = 16384
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic                    cs,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int STRB = DATA_WIDTH / 8;
    localparam int SB   = $clog2(STRB);
    localparam int IW   = $clog2(MEM_WORDS);
`ifdef AXI_SLV_DECERR_EN
    localparam bit DECERR = 1'b1;
`else
    localparam bit DECERR = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
    state_t state, nxt;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic                  prio;
    logic [ID_WIDTH-1:0]   id;
    logic [LEN_WIDTH-1:0]  len, cnt;
    logic                  fixed, err, dec;
    logic [IW-1:0]         idx, sidx, nidx;
    logic [1:0]            bresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  aw_hs, ar_hs, w_hs, r_hs, at_len, w_end, r_end, sdec;
    logic [ADDR_WIDTH-SB-1:0] word;
    // byte-lane address bits carry no information for a word-addressed SRAM
    logic unused;
    assign unused = ^{awaddr[SB-1:0], araddr[SB-1:0]};
    always_ff @(posedge ck) state <= rst ? IDLE : nxt;
    // prio=0: write side owns the tie, prio=1: read side owns it
    always_comb begin
        nxt     = state;
        awready = !rst && state == IDLE && cs && (!arvalid || !prio);
        arready = !rst && state == IDLE && cs && (!awvalid || prio);
        wready  = !rst && state == WDATA;
        bvalid  = !rst && state == WRESP;
        rvalid  = !rst && state == RDATA;
        aw_hs   = awvalid && awready;
        ar_hs   = arvalid && arready;
        w_hs    = wvalid && wready;
        r_hs    = rvalid && rready;
        at_len  = cnt == len;
        w_end   = w_hs && (at_len || wlast);
        r_end   = r_hs && at_len;
        word    = aw_hs ? awaddr[ADDR_WIDTH-1:SB] : araddr[ADDR_WIDTH-1:SB];
        sidx    = IW'(32'(word) % MEM_WORDS);
        sdec    = DECERR && (32'(word) >= 32'(MEM_WORDS));
        nidx    = fixed ? idx : (32'(idx) == 32'(MEM_WORDS - 1)) ? '0 : idx + 1'b1;
        case (state)
            IDLE:    nxt = aw_hs ? WDATA : ar_hs ? RDATA : IDLE;
            WDATA:   nxt = w_end ? WRESP : WDATA;
            WRESP:   nxt = (bvalid && bready) ? IDLE : WRESP;
            default: nxt = r_end ? IDLE : RDATA;
        endcase
    end
    always_ff @(posedge ck) begin
        if (rst) begin
            prio    <= 1'b0;
            id      <= '0;
            len     <= '0;
            cnt     <= '0;
            fixed   <= 1'b0;
            err     <= 1'b0;
            dec     <= 1'b0;
            idx     <= '0;
            bresp_q <= 2'b00;
            rdata_q <= '0;
        end else begin
            if (aw_hs || ar_hs) begin
                prio  <= aw_hs;
                id    <= aw_hs ? awid : arid;
                len   <= aw_hs ? awlen : arlen;
                cnt   <= '0;
                fixed <= (aw_hs ? awburst : arburst) == 2'b00;
                err   <= (aw_hs ? awsize : arsize) != 3'(SB);
                dec   <= sdec;
                idx   <= sidx;
            end
            if (w_hs || r_hs) begin
                cnt <= cnt + 1'b1;
                idx <= nidx;
            end
            if (w_end)
                bresp_q <= dec ? 2'b11 : (err || wlast != at_len) ? 2'b10 : 2'b00;
            // registered read: next beat is fetched as the current one is accepted
            if (ar_hs || (r_hs && !at_len))
                rdata_q <= (ar_hs ? sdec : dec) ? '0 : mem[ar_hs ? sidx : nidx];
        end
    end
    always_ff @(posedge ck)
        if (w_hs && !dec)
            for (int i = 0; i < STRB; i++)
                if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    assign bid   = id;
    assign bresp = bresp_q;
    assign rid   = id;
    assign rdata = rdata_q;
    assign rresp = dec ? 2'b11 : err ? 2'b10 : 2'b00;
    assign rlast = rvalid && at_len;
endmodule
